// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate type, used by the
// timing generator and by the renderer that consumes its coordinates.
package vga_pkg;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Sync windows are inclusive on both ends: hsync low on x=656..751, vsync low on y=490..491.
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  localparam int PIX_DIV = 4;

  typedef enum logic [0:0] {
    TS_RESTART,
    TS_RUN
  } timing_state_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  function automatic coord_t step_wrap(input coord_t v, input coord_t last);
    return (v == last) ? '0 : coord_t'(v + coord_t'(1));
  endfunction

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: coordinates, syncs, blanking and pixel strobes
// driven by vga_timing (master) and consumed by the renderer (slave).
interface vga_timing_if;
  import vga_pkg::*;

  coord_t x;
  coord_t y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   pix_en;
  logic   frame_start;

  modport master (
    output x, y, hsync, vsync, video_on, pix_en, frame_start
  );

  modport slave (
    input x, y, hsync, vsync, video_on, pix_en, frame_start
  );

endinterface

// File: rtl/vga_timing_pix_div.sv
// Divide-by-4 pixel enable (100 MHz clk to 25 MHz pixel rate).
// Only built when VGA_PIX_DIV_EN is defined.
`ifdef VGA_PIX_DIV_EN
module pix_div (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  logic [1:0] div_reg;
  logic       pix_en_reg;

  // Registered strobe: first pulse lands on the 4th edge after reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg    <= 2'd0;
      pix_en_reg <= 1'b0;
    end else begin
      div_reg    <= div_reg + 2'd1;
      pix_en_reg <= (div_reg == 2'd3);
    end
  end

  assign pix_en = pix_en_reg;

endmodule
`endif

// File: rtl/vga_timing.sv
// VGA raster timing generator: 11-bit x/y counters with registered, skew-free
// sync/blank outputs. Define VGA_PIX_DIV_EN to advance on every 4th clk via pix_div.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int     H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic pix_en;

`ifdef VGA_PIX_DIV_EN
  pix_div u_pix_div (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en)
  );
`else
  logic pix_en_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_reg <= 1'b0;
    end else begin
      pix_en_reg <= 1'b1;
    end
  end

  assign pix_en = pix_en_reg;
`endif

  coord_t        x_reg;
  coord_t        y_reg;
  coord_t        x_next;
  coord_t        y_next;
  logic          frame_wrap;
  sync_t         sync_reg;
  sync_t         sync_next;
  logic          frame_start_reg;
  timing_state_t state_reg;

  // Compare-and-wrap counters; y only moves on the edge where x wraps.
  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    frame_wrap = 1'b0;
    if (pix_en) begin
      x_next = step_wrap(x_reg, H_LAST);
      if (x_reg == H_LAST) begin
        y_next     = step_wrap(y_reg, V_LAST);
        frame_wrap = (y_reg == V_LAST);
      end
    end
  end

  // Decoded from the next coordinates so the registered syncs line up with x/y.
  assign sync_next = '{
    hsync:    ~in_range(x_next, HS_FIRST, HS_LAST),
    vsync:    ~in_range(y_next, VS_FIRST, VS_LAST),
    video_on: (x_next < H_VIS) && (y_next < V_VIS)
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= TS_RESTART;
      x_reg           <= '0;
      y_reg           <= '0;
      sync_reg        <= '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};
      frame_start_reg <= 1'b0;
    end else begin
      x_reg    <= x_next;
      y_reg    <= y_next;
      sync_reg <= sync_next;
      case (state_reg)
        // The first edge out of reset presents (0,0) as a fresh frame.
        TS_RESTART: begin
          frame_start_reg <= 1'b1;
          state_reg       <= TS_RUN;
        end
        default: begin
          frame_start_reg <= frame_wrap;
          state_reg       <= TS_RUN;
        end
      endcase
    end
  end

  assign vga.x           = x_reg;
  assign vga.y           = y_reg;
  assign vga.hsync       = sync_reg.hsync;
  assign vga.vsync       = sync_reg.vsync;
  assign vga.video_on    = sync_reg.video_on;
  assign vga.pix_en      = pix_en;
  assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance and a shrunken-geometry
// instance, both checked every cycle against a closed-form raster model.
module tb_vga_timing;
  import vga_pkg::*;

`ifdef VGA_PIX_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  localparam int S_HA = 16, S_HFP = 4, S_HS = 6, S_HBP = 6;
  localparam int S_VA = 12, S_VFP = 3, S_VS = 2, S_VBP = 4;
  localparam int S_FRAME = (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP);
  localparam int CYCLE_BUDGET = 80000;
  localparam int MAX_MISS = 100;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        pix_en;
    logic        frame_start;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if vif_d ();
  vga_timing_if vif_s ();

  vga_timing u_dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vif_d)
  );

  vga_timing #(
    .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .vga   (vif_s)
  );

  obs_t obs_d, obs_s;
  assign obs_d = {vif_d.x, vif_d.y, vif_d.hsync, vif_d.vsync, vif_d.video_on, vif_d.pix_en, vif_d.frame_start};
  assign obs_s = {vif_s.x, vif_s.y, vif_s.hsync, vif_s.vsync, vif_s.video_on, vif_s.pix_en, vif_s.frame_start};

  int vectors = 0;
  int miscompares = 0;
  int n = -1;    // edges since reset release; 0 while reset is sampled high
  int cyc = 0;

  // Counter advances seen after edge e: the enable visible before edge e must be high.
  function automatic int ticks(input int e);
    return (e < 1) ? 0 : (e - 1) / DIV;
  endfunction

  function automatic obs_t model(input int e, input int ha, input int hfp, input int hs, input int hbp,
                                 input int va, input int vfp, input int vs, input int vbp);
    obs_t o;
    int ht, fr, p, px, py;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    if (e < 1) return o;
    ht = ha + hfp + hs + hbp;
    fr = ht * (va + vfp + vs + vbp);
    p  = ticks(e) % fr;
    px = p % ht;
    py = p / ht;
    o.x           = 11'(px);
    o.y           = 11'(py);
    o.hsync       = !((px >= ha + hfp) && (px < ha + hfp + hs));
    o.vsync       = !((py >= va + vfp) && (py < va + vfp + vs));
    o.video_on    = (px < ha) && (py < va);
    o.pix_en      = ((e % DIV) == 0);
    o.frame_start = (e == 1) || ((p == 0) && (ticks(e) != ticks(e - 1)));
    return o;
  endfunction

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s edge=%0d got x=%0d y=%0d hs=%b vs=%b von=%b pe=%b fs=%b want x=%0d y=%0d hs=%b vs=%b von=%b pe=%b fs=%b",
               name, n, got.x, got.y, got.hsync, got.vsync, got.video_on, got.pix_en, got.frame_start,
               exp.x, exp.y, exp.hsync, exp.vsync, exp.video_on, exp.pix_en, exp.frame_start);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s edge=%0d got %0d want %0d", name, n, got, exp);
    end
  endtask

  // One clock: drive reset, take the edge, then compare both instances on the falling edge.
  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk);
    if (rst) n = 0;
    else if (n >= 0) n++;
    cyc++;
    @(negedge clk);
    if (n >= 0) begin
      check_obs("model_std", obs_d, model(n, 640, 16, 96, 48, 480, 10, 2, 33));
      check_obs("model_small", obs_s, model(n, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP));
    end
    if (miscompares > MAX_MISS) finish_run();
  endtask

  initial begin
    obs_t rst_exp;
    int hs_low, first_hs_x, von_cnt, s_vs_low, s_von, s_fs, guard;
    rst_exp = '0;
    rst_exp.hsync = 1'b1;
    rst_exp.vsync = 1'b1;

    repeat (3) step(1'b1);
    check_obs("reset_literal", obs_d, rst_exp);
    $display("txn reset: x=%0d y=%0d hs=%b vs=%b", vif_d.x, vif_d.y, vif_d.hsync, vif_d.vsync);

    // First full line of the default instance plus first frame of the small one.
    hs_low = 0; first_hs_x = -1; von_cnt = 0; s_vs_low = 0; s_von = 0; s_fs = 0;
    for (int e = 1; e <= 800 * DIV + 1; e++) begin
      step(1'b0);
      if (e == 1) begin
        check_val("first_edge_x", vif_d.x, 0);
        check_val("first_edge_y", vif_d.y, 0);
        check_val("first_edge_video_on", vif_d.video_on, 1);
        check_val("first_edge_frame_start", vif_d.frame_start, 1);
      end
      if (e == 1 + DIV) begin
        check_val("second_tick_x", vif_d.x, 1);
        check_val("second_tick_frame_start", vif_d.frame_start, 0);
      end
      if (e == 640 * DIV + 1) begin
        check_val("x640_x", vif_d.x, 640);
        check_val("x640_video_on", vif_d.video_on, 0);
      end
      if (e <= 800 * DIV) begin
        if (!vif_d.hsync) begin
          hs_low++;
          if (first_hs_x < 0) first_hs_x = int'(vif_d.x);
        end
        von_cnt += int'(vif_d.video_on);
      end
      if (e <= S_FRAME * DIV) begin
        s_vs_low += int'(!vif_s.vsync);
        s_von    += int'(vif_s.video_on);
        s_fs     += int'(vif_s.frame_start);
      end
      if (e == S_FRAME * DIV + 1) begin
        check_val("small_wrap_x", vif_s.x, 0);
        check_val("small_wrap_y", vif_s.y, 0);
        check_val("small_wrap_frame_start", vif_s.frame_start, 1);
      end
    end
    check_val("line_wrap_x", vif_d.x, 0);
    check_val("line_wrap_y", vif_d.y, 1);
    check_val("hsync_low_count", hs_low, 96 * DIV);
    check_val("hsync_first_x", first_hs_x, 656);
    check_val("line0_video_on_count", von_cnt, 640 * DIV);
    check_val("small_vsync_low_count", s_vs_low, 2 * 32 * DIV);
    check_val("small_video_on_count", s_von, 16 * 12 * DIV);
    check_val("small_frame_start_count", s_fs, 1);
    $display("txn line: hs_low=%0d first_hs_x=%0d von=%0d small_vs_low=%0d", hs_low, first_hs_x, von_cnt, s_vs_low);

    // Mid-frame reset at (300,10).
    guard = 0;
    while (!(vif_d.x == 11'd300 && vif_d.y == 11'd10) && guard < 9000 * DIV) begin
      step(1'b0);
      guard++;
    end
    check_val("reach_300_10", {10'd0, vif_d.y, vif_d.x}, {10'd0, 11'd10, 11'd300});
    step(1'b1);
    check_obs("midframe_reset_literal", obs_d, rst_exp);
    step(1'b0);
    check_val("after_reset_x", vif_d.x, 0);
    check_val("after_reset_y", vif_d.y, 0);
    check_val("after_reset_hsync", vif_d.hsync, 1);
    check_val("after_reset_vsync", vif_d.vsync, 1);
    check_val("after_reset_frame_start", vif_d.frame_start, 1);
    $display("txn midframe reset: x=%0d y=%0d fs=%b", vif_d.x, vif_d.y, vif_d.frame_start);

    // Random run lengths punctuated by short resets.
    while (cyc < CYCLE_BUDGET) begin
      int len, rl;
      len = int'($urandom_range(200, 6000));
      rl  = int'($urandom_range(1, 3));
      for (int i = 0; i < len && cyc < CYCLE_BUDGET; i++) step(1'b0);
      $display("txn run len=%0d ended at x=%0d y=%0d", len, vif_d.x, vif_d.y);
      for (int i = 0; i < rl; i++) step(1'b1);
      $display("txn reset len=%0d", rl);
    end

    finish_run();
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels; line total is 800.
REQ-005 SHALL have parameters V_ACTIVE, default 480, and V_FP, default 10, meaning visible lines and vertical front porch in lines.
REQ-006 SHALL have parameters V_SYNC, default 2, and V_BP, default 33, meaning vsync width and vertical back porch in lines; frame total is 525.
REQ-007 SHALL have port clk, input, 1 bit, meaning system clock; one clock domain only.
REQ-008 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-009 SHALL have port x, output, 11 bits, meaning current horizontal pixel counter, 0..799.
REQ-010 SHALL have port y, output, 11 bits, meaning current line counter, 0..524.
REQ-011 SHALL have port hsync, output, 1 bit, meaning active-low horizontal sync.
REQ-012 SHALL have port vsync, output, 1 bit, meaning active-low vertical sync.
REQ-013 SHALL have port video_on, output, 1 bit, meaning (x,y) lies in the visible area.
REQ-014 SHALL have port pix_en, output, 1 bit, meaning pixel-rate enable; counters advance on clk edges where it is 1.
REQ-015 SHALL have port frame_start, output, 1 bit, meaning one-clk strobe when (x,y) becomes (0,0).

Function
REQ-016 x SHALL increment by 1 on each clk edge with pix_en=1, wrapping from 799 to 0.
REQ-017 y SHALL increment by 1 only on the edge where x wraps, wrapping from 524 to 0 on the same edge.
REQ-018 x and y SHALL hold their values on edges with pix_en=0.
REQ-019 hsync SHALL be 0 exactly when x is in 656..751, and 1 otherwise.
REQ-020 vsync SHALL be 0 exactly when y is in 490..491, and 1 otherwise.
REQ-021 video_on SHALL be 1 exactly when x<640 and y<480.
REQ-022 hsync, vsync and video_on SHALL be registered from the next counter value so they are cycle-aligned with x and y, with zero relative skew.
REQ-023 frame_start SHALL be 1 for exactly one clk in the first cycle that (x,y)=(0,0) after a frame wrap, and SHALL be 0 on the held cycles that follow.
REQ-024 All counter arithmetic SHALL be 11-bit unsigned; compare-and-wrap SHALL be used, not overflow.

Reset
REQ-025 While reset=1: x=0, y=0, hsync=1, vsync=1, video_on=0, frame_start=0, pix_en=0, and the divider is 0.
REQ-026 On the first clk edge after reset deasserts: x=0, y=0, video_on=1, and frame_start=1 for one clk.
REQ-027 Reset asserted mid-frame SHALL take effect on the next clk edge, regardless of pix_en.

Configuration
REQ-028 With macro VGA_PIX_DIV_EN defined, a 2-bit divider SHALL make pix_en=1 on every 4th clk (100 MHz to 25 MHz); the first pulse is on the 4th edge after reset release.
REQ-029 Without VGA_PIX_DIV_EN, pix_en SHALL be 1 on every clk after reset and the divider SHALL NOT be present.

Structure
REQ-030 The timing constants (H/V totals, sync start/end) and the 11-bit coordinate width SHALL live in shared package vga_pkg, which the renderer also uses.
REQ-031 The pixel divider SHALL be a sub-module named pix_div, instantiated only under VGA_PIX_DIV_EN.
REQ-032 There SHALL be no other sub-modules.

Verification
REQ-033 Release reset, no macro: after 800 clks x=0 and y=1; hsync is low for exactly 96 clks, starting at x=656.
REQ-034 Run 420000 clks, no macro: vsync is low for exactly 1600 clks (y=490..491), and frame_start pulses once per 420000 clks.
REQ-035 With VGA_PIX_DIV_EN: pix_en has period 4 clks, x steps once per 4 clks, and a full frame takes 1680000 clks.
REQ-036 Count video_on=1 clks over one frame, no macro: the count is 307200; video_on is 0 at x=640 and at y=480.
REQ-037 Assert reset for 1 clk at (x,y)=(300,200), then release: the next edge gives x=0, y=0, hsync=1, vsync=1, and frame_start=1 for one clk.
